// File: rtl/and_power_activity_monitor.sv
// Measures toggle and high-cycle counts of sig_in over a latched window of win_len cycles.
// Latency: the report is valid one cycle after the last sampled edge of the window.
// Backpressure: the report is held stable until rpt_ready; nothing is sampled while it waits.
// Optional: define ACT_MON_PEAK_EN to add rpt_peak (the running maximum of rpt_toggles).
module and_power_activity_monitor #(
    parameter int WIN_W = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIN_W-1:0] win_len,
    input  logic             sig_in,
    output logic             rpt_valid,
    input  logic             rpt_ready,
    output logic [CNT_W-1:0] rpt_toggles,
    output logic [CNT_W-1:0] rpt_high,
    output logic             rpt_overflow,
    output logic             busy
`ifdef ACT_MON_PEAK_EN
    ,
    output logic [CNT_W-1:0] rpt_peak
`endif
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] MEAS   = 2'd1;
    localparam logic [1:0] REPORT = 2'd2;

    localparam logic [WIN_W-1:0] WIN_ONE = WIN_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [1:0]       state;
    logic             sig_q;
    logic [WIN_W-1:0] len_q;
    logic [WIN_W-1:0] cycle_cnt;
    logic [CNT_W-1:0] tog_cnt;
    logic [CNT_W-1:0] high_cnt;
    logic             ovf_q;

    logic             toggle;
    logic [CNT_W-1:0] tog_nxt;
    logic [CNT_W-1:0] high_nxt;
    logic             ovf_nxt;
    logic             last_sample;
    logic             start_ok;

    assign busy = (state != IDLE);

    // Saturating next values for the working counters; an increment attempted at max flags overflow.
    always_comb begin
        toggle      = (sig_in != sig_q);
        tog_nxt     = tog_cnt;
        high_nxt    = high_cnt;
        ovf_nxt     = ovf_q;
        if (toggle) begin
            if (&tog_cnt) ovf_nxt = 1'b1;
            else          tog_nxt = tog_cnt + CNT_ONE;
        end
        if (sig_in) begin
            if (&high_cnt) ovf_nxt = 1'b1;
            else           high_nxt = high_cnt + CNT_ONE;
        end
        last_sample = (cycle_cnt == (len_q - WIN_ONE));
        start_ok    = en && (win_len != '0);
    end

    // sig_q tracks sig_in in every state so the first sample of a window sees a true previous value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sig_q <= 1'b0;
        else        sig_q <= sig_in;
    end

    // Window control, working counters and the report register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            len_q        <= '0;
            cycle_cnt    <= '0;
            tog_cnt      <= '0;
            high_cnt     <= '0;
            ovf_q        <= 1'b0;
            rpt_valid    <= 1'b0;
            rpt_toggles  <= '0;
            rpt_high     <= '0;
            rpt_overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_ok) begin
                        state     <= MEAS;
                        len_q     <= win_len;
                        cycle_cnt <= '0;
                        tog_cnt   <= '0;
                        high_cnt  <= '0;
                        ovf_q     <= 1'b0;
                    end
                end
                MEAS: begin
                    if (!en) begin
                        // Abort: discard the partial window.
                        state     <= IDLE;
                        cycle_cnt <= '0;
                        tog_cnt   <= '0;
                        high_cnt  <= '0;
                        ovf_q     <= 1'b0;
                    end else begin
                        tog_cnt   <= tog_nxt;
                        high_cnt  <= high_nxt;
                        ovf_q     <= ovf_nxt;
                        cycle_cnt <= cycle_cnt + WIN_ONE;
                        if (last_sample) begin
                            state        <= REPORT;
                            rpt_valid    <= 1'b1;
                            rpt_toggles  <= tog_nxt;
                            rpt_high     <= high_nxt;
                            rpt_overflow <= ovf_nxt;
                        end
                    end
                end
                REPORT: begin
                    if (rpt_ready) begin
                        rpt_valid <= 1'b0;
                        if (start_ok) begin
                            state     <= MEAS;
                            len_q     <= win_len;
                            cycle_cnt <= '0;
                            tog_cnt   <= '0;
                            high_cnt  <= '0;
                            ovf_q     <= 1'b0;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ACT_MON_PEAK_EN
    // Running maximum of reported toggle counts, updated as each report loads; only reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rpt_peak <= '0;
        end else if (state == MEAS && en && last_sample && tog_nxt > rpt_peak) begin
            rpt_peak <= tog_nxt;
        end
    end
`endif

endmodule
